data_cal_multi: RTL and testbench

Parametrised nibble-arithmetic unit. It is the successor to the fixed 16-bit, 4-nibble data calculator in the basic block set. A load command captures an `NIB_N × NIB_W` data word. Later select commands combine lane 0 with a chosen lane under one of four modes: sum, absolute difference, saturating accumulate, or maximum. Each result is registered and flagged valid. It sits behind the command decoder, and its result feeds the display/checker logic.

---
 rtl/data_cal_multi.sv | 76 +++++++
 tb/tb_data_cal_multi.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/data_cal_multi.sv
// Parametrised nibble-arithmetic unit: a load captures a multi-lane word, and select
// commands combine lane 0 with a chosen lane (sum, abs diff, saturating accumulate, max).
module data_cal_multi #(
  parameter int NIB_W = 4,
  parameter int NIB_N = 4,
  parameter int SEL_W = 2,
  parameter int ACC_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NIB_W*NIB_N-1:0] d,
  input  logic [SEL_W-1:0]       sel,
  input  logic [1:0]             mode,
  output logic [ACC_W-1:0]       out,
  output logic                   validout,
  output logic                   loaded
);

  logic [NIB_W*NIB_N-1:0] d_reg;
  logic [ACC_W-1:0]       acc;

  logic [NIB_W-1:0] a;
  logic [NIB_W-1:0] b;
  logic [NIB_W-1:0] diff;
  logic             sel_ok;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_sat;
  logic [ACC_W-1:0] res;

  always_comb begin
    a      = d_reg[NIB_W-1:0];
    b      = '0;
    sel_ok = 1'b0;
    // Only lanes 1..NIB_N-1 are computable; any other nonzero select is out of range.
    for (int k = 1; k < NIB_N; k++) begin
      if (sel == SEL_W'(k)) begin
        b      = d_reg[k*NIB_W +: NIB_W];
        sel_ok = 1'b1;
      end
    end
    diff    = (a >= b) ? (a - b) : (b - a);
    acc_sum = {1'b0, acc} + (ACC_W+1)'(a) + (ACC_W+1)'(b);
    acc_sat = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    case (mode)
      2'b00:   res = ACC_W'(a) + ACC_W'(b);
      2'b01:   res = ACC_W'(diff);
      2'b10:   res = acc_sat;
      default: res = (a >= b) ? ACC_W'(a) : ACC_W'(b);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_reg    <= '0;
      acc      <= '0;
      loaded   <= 1'b0;
      out      <= '0;
      validout <= 1'b0;
    end else if (sel == '0) begin
      d_reg    <= d;
      loaded   <= 1'b1;
      acc      <= '0;
      out      <= '0;
      validout <= 1'b0;
    end else if (sel_ok && loaded) begin
      out      <= res;
      validout <= 1'b1;
      if (mode == 2'b10)
        acc <= acc_sat;
    end else begin
      out      <= '0;
      validout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_cal_multi.sv
// Bench for data_cal_multi: directed scenarios plus randomized commands checked
// against an arithmetic reference model.
module tb_data_cal_multi;
  localparam int NW = 4;
  localparam int AW = 8;
  localparam int AMAX = (1 << AW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] d_a = '0;
  logic [1:0]  sel_a = 2'd1;
  logic [1:0]  mode_a = 2'd0;
  logic [7:0]  out_a;
  logic        valid_a, loaded_a;
  logic [11:0] d_b = '0;
  logic [1:0]  sel_b = 2'd1;
  logic [1:0]  mode_b = 2'd0;
  logic [7:0]  out_b;
  logic        valid_b, loaded_b;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_word, m_acc, m_out, m_valid, m_loaded;

  data_cal_multi dut_a (
    .clk(clk), .rst(rst), .d(d_a), .sel(sel_a), .mode(mode_a),
    .out(out_a), .validout(valid_a), .loaded(loaded_a)
  );

  data_cal_multi #(.NIB_N(3)) dut_b (
    .clk(clk), .rst(rst), .d(d_b), .sel(sel_b), .mode(mode_b),
    .out(out_b), .validout(valid_b), .loaded(loaded_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_word = 0; m_acc = 0; m_out = 0; m_valid = 0; m_loaded = 0;
  endtask

  task automatic model_step(input int s, input int m, input int dv);
    int a, b;
    if (s == 0) begin
      m_word = dv; m_loaded = 1; m_acc = 0; m_out = 0; m_valid = 0;
    end else if (s >= 4 || m_loaded == 0) begin
      m_out = 0; m_valid = 0;
    end else begin
      a = m_word % 16;
      b = (m_word / (1 << (NW * s))) % 16;
      case (m)
        0: m_out = a + b;
        1: m_out = (a > b) ? a - b : b - a;
        2: begin
          m_acc = (m_acc + a + b > AMAX) ? AMAX : m_acc + a + b;
          m_out = m_acc;
        end
        default: m_out = (a > b) ? a : b;
      endcase
      m_valid = 1;
    end
  endtask

  // Drive one command on dut_a at the falling edge, check just after the rising edge.
  task automatic cmd(input int s, input int m, input int dv, input string tag);
    @(negedge clk);
    sel_a = s[1:0]; mode_a = m[1:0]; d_a = dv[15:0];
    model_step(s, m, dv);
    @(posedge clk);
    #1;
    chk({tag, ".out"}, int'(out_a), m_out);
    chk({tag, ".valid"}, int'(valid_a), m_valid);
    chk({tag, ".loaded"}, int'(loaded_a), m_loaded);
  endtask

  initial begin
    model_reset();
    #22;
    @(negedge clk);
    rst = 1'b1;

    // power-up compute without load
    cmd(1, 0, 16'h1234, "tp1");
    chk("tp1.out_const", int'(out_a), 0);

    // basic modes
    cmd(0, 3, 16'hA5C3, "tp2.load");
    cmd(1, 0, 0, "tp2.sum");   chk("tp2.sum_const", int'(out_a), 15);
    cmd(3, 1, 0, "tp2.diff");  chk("tp2.diff_const", int'(out_a), 7);
    cmd(2, 3, 0, "tp2.max");   chk("tp2.max_const", int'(out_a), 5);

    // accumulate and clear on load
    cmd(0, 0, 16'hA5C3, "tp3.load");
    for (int i = 1; i <= 3; i++) begin
      cmd(1, 2, 0, "tp3.acc");
      chk("tp3.acc_const", int'(out_a), 15 * i);
    end
    cmd(0, 2, 16'h0000, "tp3.reload");
    chk("tp3.reload_valid", int'(valid_a), 0);
    cmd(1, 2, 0, "tp3.acc_cleared");
    chk("tp3.acc_cleared_const", int'(out_a), 0);

    // saturation
    cmd(0, 0, 16'hFFFF, "tp4.load");
    for (int i = 1; i <= 10; i++) begin
      cmd(1, 2, 0, "tp4.acc");
      chk("tp4.acc_const", int'(out_a), (30 * i > 255) ? 255 : 30 * i);
    end

    // async reset mid-sequence
    cmd(0, 0, 16'h00F1, "tp6.load");
    cmd(1, 2, 0, "tp6.acc1");
    cmd(1, 2, 0, "tp6.acc2");
    #2 rst = 1'b0;
    #1;
    chk("tp6.rst_out", int'(out_a), 0);
    chk("tp6.rst_valid", int'(valid_a), 0);
    chk("tp6.rst_loaded", int'(loaded_a), 0);
    chk("tp6.rst_acc", int'(dut_a.acc), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd(1, 0, 0, "tp6.after");
    chk("tp6.after_valid", int'(valid_a), 0);

    // randomized commands
    for (int i = 0; i < 400; i++) begin
      int s;
      s = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 3);
      cmd(s, $urandom_range(0, 3), $urandom_range(0, 16'hFFFF), "rnd");
    end

    // three-lane instance: out-of-range select
    @(negedge clk);
    sel_b = 2'd0; d_b = 12'h321;
    @(negedge clk);
    sel_b = 2'd3; mode_b = 2'd0;
    @(posedge clk); #1;
    chk("tp5.oor_out", int'(out_b), 0);
    chk("tp5.oor_valid", int'(valid_b), 0);
    @(negedge clk);
    sel_b = 2'd2; mode_b = 2'd0;
    @(posedge clk); #1;
    chk("tp5.sum_out", int'(out_b), 4);
    chk("tp5.sum_valid", int'(valid_b), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
